// File: rtl/piano_pkg.sv
// Shared constants for the piano display pipeline: key geometry defaults,
// key index encoding and the colours the downstream colour stage paints with.
package piano_pkg;

  localparam int NUM_KEYS  = 7;
  localparam int KEY_IDX_W = 3;
  localparam int ADDR_W    = 17;
  localparam int HOLD_W    = 8;

  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  localparam key_idx_t KEY_NONE = 3'd7;

  localparam logic [9:0] DEF_X0          = 10'd40;
  localparam logic [9:0] DEF_Y0          = 10'd280;
  localparam logic [9:0] DEF_KEY_W       = 10'd80;
  localparam logic [9:0] DEF_KEY_H       = 10'd160;
  localparam int         DEF_IMG_W       = 320;
  localparam int         DEF_HOLD_FRAMES = 8;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COLOR_KEY_UP   = 12'hFFF;
  localparam rgb_t COLOR_KEY_DOWN = 12'hF80;
  localparam rgb_t COLOR_KEY_EDGE = 12'h000;

  // Left edge of key i, widened to 11 bits so the band end (X0 + 7*KEY_W) cannot wrap.
  function automatic logic [10:0] key_left(input logic [9:0] x0,
                                           input logic [9:0] key_w,
                                           input int         idx);
    return 11'(x0) + 11'(key_w) * 11'(idx);
  endfunction

endpackage

// File: rtl/piano_key_locator_if.sv
// Scan-position in / key-location out bundle between the VGA timing side
// (master) and the key locator (slave).
interface piano_key_locator_if;
  import piano_pkg::*;

  logic [9:0]          h_cnt;
  logic [9:0]          v_cnt;
  logic                valid_in;
  logic                frame_start;
  logic [NUM_KEYS-1:0] key_in;

  logic [ADDR_W-1:0]   pixel_addr;
  key_idx_t            key;
  logic                down;
  logic                valid;

  modport master (
    output h_cnt, v_cnt, valid_in, frame_start, key_in,
    input  pixel_addr, key, down, valid
  );

  modport slave (
    input  h_cnt, v_cnt, valid_in, frame_start, key_in,
    output pixel_addr, key, down, valid
  );

endinterface

// File: rtl/piano_key_hold.sv
// One key's press-edge detector and frame hold counter; keeps the key lit for
// HOLD_FRAMES frame updates after a press edge even if the press was short.
module piano_key_hold
  import piano_pkg::*;
#(
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  input  logic i_frame_start,
  output logic o_next_state
);

  logic              r_key_prev;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_rise;

  assign w_rise = i_key & ~r_key_prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_prev <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_key_prev <= i_key;
      if (w_rise)
        r_hold_cnt <= HOLD_W'(HOLD_FRAMES);
      else if (i_frame_start && (r_hold_cnt != '0))
        r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  assign o_next_state = i_key | (r_hold_cnt != '0);

endmodule

// File: rtl/piano_key_locator.sv
// Maps the VGA scan position to a piano key index and pressed flag, and issues
// the half-resolution background ROM address. Optional hold: PIANO_KEY_HOLD_EN.
module piano_key_locator
  import piano_pkg::*;
#(
  parameter logic [9:0] X0    = DEF_X0,
  parameter logic [9:0] Y0    = DEF_Y0,
  parameter logic [9:0] KEY_W = DEF_KEY_W,
  parameter logic [9:0] KEY_H = DEF_KEY_H,
  parameter int         IMG_W = DEF_IMG_W
`ifdef PIANO_KEY_HOLD_EN
  ,
  parameter int         HOLD_FRAMES = DEF_HOLD_FRAMES
`endif
) (
  input logic               clk,
  input logic               rst_n,
  piano_key_locator_if.slave bus
);

  localparam logic [10:0] BAND_X_END = key_left(X0, KEY_W, NUM_KEYS);
  localparam logic [10:0] BAND_Y_END = 11'(Y0) + 11'(KEY_H);

  logic [10:0]         w_h;
  logic [10:0]         w_v;
  logic                w_in_band;
  key_idx_t            w_col;
  logic [ADDR_W-1:0]   w_addr;
  logic [NUM_KEYS-1:0] w_next_state;
  logic [NUM_KEYS:0]   w_disp_ext;
  logic                w_down1;

  key_idx_t            r_col1;
  logic                r_valid1;
  logic [ADDR_W-1:0]   r_addr;
  key_idx_t            r_key;
  logic                r_down;
  logic                r_valid;
  logic [NUM_KEYS-1:0] r_disp_state;

  assign w_h = {1'b0, bus.h_cnt};
  assign w_v = {1'b0, bus.v_cnt};

  assign w_in_band = (w_v >= 11'(Y0)) && (w_v < BAND_Y_END) &&
                     (w_h >= 11'(X0)) && (w_h < BAND_X_END);

  // NOTE: w_col gets its default before the chain, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_col = KEY_NONE;
    if (w_in_band) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_h >= key_left(X0, KEY_W, i))
          w_col = key_idx_t'(i);
      end
    end
  end

  assign w_addr = ADDR_W'(bus.v_cnt >> 1) * ADDR_W'(IMG_W) + ADDR_W'(bus.h_cnt >> 1);

`ifdef PIANO_KEY_HOLD_EN
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_hold
    piano_key_hold #(
      .HOLD_FRAMES (HOLD_FRAMES)
    ) u_hold (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_key         (bus.key_in[g]),
      .i_frame_start (bus.frame_start),
      .o_next_state  (w_next_state[g])
    );
  end
`else
  assign w_next_state = bus.key_in;
`endif

  // Displayed key state only moves at frame_start so a key never tears mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_disp_state <= '0;
    else if (bus.frame_start)
      r_disp_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col1   <= KEY_NONE;
      r_valid1 <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_col1   <= w_col;
      r_valid1 <= bus.valid_in;
      r_addr   <= w_addr;
    end
  end

  // Padding with a zero at index KEY_NONE keeps the lookup in range for "no key".
  assign w_disp_ext = {1'b0, r_disp_state};
  assign w_down1    = (r_col1 != KEY_NONE) && w_disp_ext[r_col1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= KEY_NONE;
      r_down  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_key   <= r_col1;
      r_down  <= w_down1;
      r_valid <= r_valid1;
    end
  end

  assign bus.pixel_addr = r_addr;
  assign bus.key        = r_key;
  assign bus.down       = r_down;
  assign bus.valid      = r_valid;

endmodule

// File: doc/piano_key_locator.md
Name: piano_key_locator

Overview:
- Pipeline stage directly upstream of the pixel colour stage.
- From the VGA scan position it computes which piano key the current pixel falls on, and whether that key is pressed.
- Also generates the background-image ROM address.
- Outputs key index, down flag and valid, aligned with the ROM pixel (1-cycle read latency). The colour stage consumes all four in the same cycle.

Parameters:
- X0, 10'd40: left edge (pixels) of key 0.
- Y0, 10'd280: top edge of the key band.
- KEY_W, 10'd80: width of each of the 7 keys.
- KEY_H, 10'd160: height of the key band.
- IMG_W, 320: background image width; the ROM is addressed at half resolution.
- HOLD_FRAMES, 8: frames a key stays lit after its press edge (optional feature only).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- h_cnt  in  10  current horizontal pixel.
- v_cnt  in  10  current vertical line.
- valid_in  in  1  scan position is in the visible area.
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge).
- key_in  in  7  level key states from the keyboard decoder, bit i = key i.
- pixel_addr  out  17  background ROM address, registered.
- key  out  3  key index 0..6; 7 = outside the key band.
- down  out  1  the key at this pixel is pressed.
- valid  out  1  delayed valid_in.

Behaviour:
- Reset value of every output is 0, except key, which resets to 3'd7. All pipeline and state registers clear.
- Stage 1 (registered on the cycle after inputs):
  - in_band = (v_cnt >= Y0) && (v_cnt < Y0+KEY_H) && (h_cnt >= X0) && (h_cnt < X0+7*KEY_W).
  - col = i when X0+i*KEY_W <= h_cnt < X0+(i+1)*KEY_W. Use a compare chain; no divider.
  - col = 7 when not in_band.
  - pixel_addr = (v_cnt>>1)*IMG_W + (h_cnt>>1), truncated to 17 bits.
  - valid1 = valid_in.
- Stage 2 (outputs):
  - key = col1.
  - down = (col1 != 7) && disp_state[col1].
  - valid = valid1.
- Total latency h_cnt/v_cnt -> key/down/valid is 2 cycles. The ROM pixel, addressed at stage 1, arrives in the same cycle.
- disp_state[6:0] updates only on frame_start, so a key's colour never changes mid-frame (no tearing):
  - disp_state <= next_state at frame_start.
  - Otherwise disp_state holds.
- Base next_state = key_in, sampled in the same cycle as the frame_start pulse.
- Boundaries:
  - h_cnt exactly X0+7*KEY_W gives key 7.
  - v_cnt = Y0+KEY_H-1 is still in band.
  - When valid_in=0, valid=0 two cycles later, while key and down still follow position. Downstream masks on valid.
- frame_start while stage 1/2 hold data: pixels already in flight use the new disp_state from the cycle after the update. This is accepted, because frame_start falls in blanking.
- Reset asserted mid-frame: outputs drop immediately (asynchronous). After release, disp_state is 0 until the next frame_start.

Optional Feature:
- Macro: PIANO_KEY_HOLD_EN.
- Defined:
  - Per-key 8-bit hold_cnt[i].
  - The rising edge of key_in[i] (registered previous-value compare) loads HOLD_FRAMES.
  - Each frame_start decrements every nonzero counter.
  - next_state[i] = key_in[i] | (hold_cnt[i] != 0).
  - Edge and frame_start in the same cycle: the load wins, no decrement.
  - Counter saturates at 0.
- Undefined: no counters or edge registers; next_state = key_in.

Decomposition:
- Shared package piano_pkg holds:
  - NUM_KEYS = 7.
  - KEY_NONE = 3'd7.
  - Key index width 3.
  - Default geometry constants.
  - Colour constants already used by the colour stage.
- One sub-module, piano_key_hold: the per-key edge detector plus hold counter, instantiated 7 times under PIANO_KEY_HOLD_EN.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> key=7, down=0, valid=0, pixel_addr=0. Release -> the first output appears 2 cycles after the first valid_in=1.
- Sweep h_cnt 0..639 at v_cnt=300 with valid_in=1 -> key=7 for h<40, 0 for 40..119, ..., 6 for 520..599, 7 for h>=600, each delayed by 2 cycles. pixel_addr at (100,300) = 150*320+50 = 48050.
- key_in=7'b0000100 mid-frame -> down stays 0 at key 2 until the next frame_start, then down=1 for every key-2 pixel. Key 3 pixels keep down=0.
- v_cnt=279 and v_cnt=440 at h_cnt=50 -> key=7, down=0 even with key_in=7'h7F displayed.
- With PIANO_KEY_HOLD_EN: a 1-cycle pulse on key_in[5] -> down=1 on key-5 pixels for exactly 8 frames after the next frame_start. A pulse coinciding with frame_start -> counter=8, not 7.
- Assert rst_n low mid-line with disp_state=7'h7F -> down=0 immediately. After release -> down=0 until frame_start.
